// File: rtl/ntt_pkg.sv
// Shared constants, FSM state type and index helper for the NTT coefficient loader.
package ntt_pkg;

  localparam int N  = 512;     // polynomial length, multiple of 4
  localparam int DW = 14;      // coefficient width
  localparam int AW = 7;       // per-bank address width, log2(N/4)
  localparam int IW = AW + 2;  // coefficient index width (bank select + address)

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    UNLOAD = 2'd3
  } state_t;

  // Reverse the bit order of a 9-bit coefficient index.
  function automatic logic [8:0] bitrev9(input logic [8:0] x);
    logic [8:0] r;
    for (int b = 0; b < 9; b++) begin
      r[b] = x[8-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_out_fifo2.sv
// Two-entry valid/ready FIFO with registered data; the head entry holds
// steady while out_valid is high and out_ready is low. push must only be
// raised when count < 2 (or a pop happens the same cycle).
module ntt_out_fifo2
  import ntt_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    count
);

  logic [DW-1:0] mem [2];
  logic          wptr;
  logic          rptr;
  logic [1:0]    count_q;
  logic          do_push;
  logic          do_pop;

  // Handshake flags and output view of the head entry.
  always_comb begin
    out_valid = (count_q != 2'd0);
    do_pop    = out_valid && out_ready;
    do_push   = push && ((count_q != 2'd2) || do_pop);
    out_data  = mem[rptr];
    count     = count_q;
  end

  // Storage, pointers and occupancy; reset empties the FIFO and zeros the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      wptr    <= 1'b0;
      rptr    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wptr] <= push_data;
        wptr      <= ~wptr;
      end
      if (do_pop) begin
        rptr <= ~rptr;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/ntt_coef_loader.sv
// Streams N coefficients into four interleaved banks, launches the NTT stage,
// then streams the results back out in natural order.
// Optional build macro: LOADER_BITREV_EN -- bit-reverse the load index before
// the bank/address map (unload order stays natural).
//
// Handshakes: a transfer happens on every rising edge where valid && ready;
// valid never depends on ready, and data is held while valid && !ready.
module ntt_coef_loader
  import ntt_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_start,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_data,
  output logic [3:0]      bank_we,
  output logic [AW-1:0]   bank_waddr,
  output logic [DW-1:0]   bank_wdata,
  output logic            bank_re,
  output logic [AW-1:0]   bank_raddr,
  input  logic [4*DW-1:0] bank_rdata,
  output logic            ntt_go,
  input  logic            ntt_done,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DW-1:0]   m_data,
  output logic            busy,
  output state_t          dbg_state
);

  localparam logic [IW:0] RCNT_END = (IW+1)'(N);
  localparam logic [IW-1:0] WIDX_LAST = IW'(N - 1);

  state_t        state_q;
  state_t        state_d;
  logic [IW-1:0] widx_q;      // next load index
  logic [IW:0]   rcnt_q;      // reads issued so far during unload
  logic          pend_q;      // one bank read in flight
  logic [1:0]    lane_q;      // bank lane of the read in flight
  logic          go_q;

  logic [IW-1:0] load_idx;
  logic          wr;
  logic          issue;
  logic          all_read;
  logic          pop;
  logic [1:0]    fifo_count;
  logic [1:0]    occ_after_pop;
  logic [1:0]    read_budget;
  logic [DW-1:0] push_data;
  logic          unload_done;

`ifdef LOADER_BITREV_EN
  assign load_idx = bitrev9(widx_q);
`else
  assign load_idx = widx_q;
`endif

  // Datapath strobes: bank writes during LOAD, credit-limited reads during UNLOAD.
  always_comb begin
    wr       = (state_q == LOAD) && s_valid;
    s_ready  = (state_q == LOAD);
    bank_we  = 4'b0000;
    bank_waddr = '0;
    bank_wdata = '0;
    if (state_q == LOAD) begin
      bank_waddr = load_idx[IW-1:2];
      bank_wdata = s_data;
      if (s_valid) begin
        bank_we = 4'b0001 << load_idx[1:0];
      end
    end
    pop      = m_valid && m_ready;
    all_read = (rcnt_q == RCNT_END);
    // Occupancy counted after this cycle's pop so a steady m_ready keeps one read per cycle.
    occ_after_pop = fifo_count - {1'b0, pop};
    read_budget   = occ_after_pop + {1'b0, pend_q};
    issue      = (state_q == UNLOAD) && !all_read && (read_budget < 2'd2);
    bank_re    = issue;
    bank_raddr = (state_q == UNLOAD) ? rcnt_q[IW-1:2] : '0;
    push_data  = bank_rdata[int'(lane_q)*DW +: DW];
    unload_done = all_read && !pend_q && (occ_after_pop == 2'd0);
    busy      = (state_q != IDLE);
    ntt_go    = go_q;
    dbg_state = state_q;
  end

  // Next-state logic; load_start and ntt_done are only honoured in their own states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_start) state_d = LOAD;
      LOAD:    if (wr && (widx_q == WIDX_LAST)) state_d = RUN;
      RUN:     if (ntt_done) state_d = UNLOAD;
      UNLOAD:  if (unload_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Index counters, read-in-flight tracking and the one-cycle go pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      widx_q <= '0;
      rcnt_q <= '0;
      pend_q <= 1'b0;
      lane_q <= 2'd0;
      go_q   <= 1'b0;
    end else begin
      go_q   <= (state_q == LOAD) && (state_d == RUN);
      pend_q <= issue;
      lane_q <= rcnt_q[1:0];
      if (state_q == IDLE) begin
        widx_q <= '0;
        rcnt_q <= '0;
      end else begin
        if (wr) widx_q <= widx_q + 1'b1;
        if (issue) rcnt_q <= rcnt_q + 1'b1;
      end
    end
  end

  ntt_out_fifo2 u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pend_q),
    .push_data (push_data),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_data  (m_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_ntt_coef_loader.sv
// Bench for ntt_coef_loader: behavioural bank memory, randomized load data and
// output backpressure, expected output stream held in a queue.
module tb_ntt_coef_loader;
  import ntt_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            load_start = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [DW-1:0]   s_data = '0;
  logic [3:0]      bank_we;
  logic [AW-1:0]   bank_waddr;
  logic [DW-1:0]   bank_wdata;
  logic            bank_re;
  logic [AW-1:0]   bank_raddr;
  logic [4*DW-1:0] bank_rdata;
  logic            ntt_go;
  logic            ntt_done = 1'b0;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [DW-1:0]   m_data;
  logic            busy;
  state_t          dbg_state;

  int checks = 0;
  int errors = 0;
  int go_count = 0;

  logic [DW-1:0]   bank_mem [4][N/4];
  logic [DW-1:0]   pre_val  [4][N/4];
  logic            preload_req = 1'b0;
  logic [4*DW-1:0] rdata_q = '0;
  logic [DW-1:0]   loaded [N];

  ntt_coef_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .bank_we    (bank_we),
    .bank_waddr (bank_waddr),
    .bank_wdata (bank_wdata),
    .bank_re    (bank_re),
    .bank_raddr (bank_raddr),
    .bank_rdata (bank_rdata),
    .ntt_go     (ntt_go),
    .ntt_done   (ntt_done),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Behavioural bank memory: write-through on bank_we, one-cycle read latency.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (preload_req) begin
        for (int a = 0; a < N/4; a++) bank_mem[k][a] <= pre_val[k][a];
      end else if (bank_we[k]) begin
        bank_mem[k][bank_waddr] <= bank_wdata;
      end
      if (bank_re) rdata_q[k*DW +: DW] <= bank_mem[k][bank_raddr];
    end
  end
  assign bank_rdata = rdata_q;

  // Count go pulses over the whole run.
  always @(negedge clk) begin
    if (ntt_go === 1'b1) go_count++;
  end

  // Storage position of load index i: natural, or 9-bit reversed.
  function automatic int exp_pos(input int i);
    int r;
    r = i;
`ifdef LOADER_BITREV_EN
    r = 0;
    for (int b = 0; b < 9; b++) begin
      if (((i >> b) & 1) == 1) r = r + (1 << (8 - b));
    end
`endif
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    s_data = DW'($urandom);
    s_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b want 0", s_ready); end
    checks++; if (bank_we !== 4'b0) begin errors++; $display("FAIL reset_bank_we got %b want 0", bank_we); end
    checks++; if (bank_waddr !== '0) begin errors++; $display("FAIL reset_waddr got %0d want 0", bank_waddr); end
    checks++; if (bank_wdata !== '0) begin errors++; $display("FAIL reset_wdata got %0d want 0", bank_wdata); end
    checks++; if (bank_re !== 1'b0) begin errors++; $display("FAIL reset_bank_re got %b want 0", bank_re); end
    checks++; if (bank_raddr !== '0) begin errors++; $display("FAIL reset_raddr got %0d want 0", bank_raddr); end
    checks++; if (ntt_go !== 1'b0) begin errors++; $display("FAIL reset_ntt_go got %b want 0", ntt_go); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_m_data got %0d want 0", m_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d want 0", dbg_state); end
    s_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_idle_ignores_done();
    ntt_done = 1'b1;
    @(negedge clk);
    ntt_done = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_done_busy got %b want 0", busy); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL idle_done_m_valid got %b want 0", m_valid); end
  endtask

  // Full load of N coefficients; optional s_valid toggling, random data and a stray ntt_done.
  task automatic do_load(input bit toggle, input bit rnd, input bit done_glitch);
    int i;
    int cyc;
    int pos;
    logic [DW-1:0] d;
    logic [3:0] exp_we;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    i = 0;
    cyc = 0;
    while (i < N && cyc < 4*N) begin
      s_valid  = toggle ? ((cyc % 2) == 0) : 1'b1;
      d        = rnd ? DW'($urandom) : DW'(i);
      s_data   = d;
      ntt_done = done_glitch && (cyc == 5);
      #1;
      pos    = exp_pos(i);
      exp_we = s_valid ? (4'b0001 << (pos % 4)) : 4'b0000;
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL load_s_ready idx %0d got %b want 1", i, s_ready); end
      checks++; if (ntt_go !== 1'b0) begin errors++; $display("FAIL load_early_go idx %0d got %b want 0", i, ntt_go); end
      checks++; if (bank_we !== exp_we) begin errors++; $display("FAIL load_bank_we idx %0d got %b want %b", i, bank_we, exp_we); end
      if (s_valid) begin
        checks++; if (bank_waddr !== AW'(pos / 4)) begin errors++; $display("FAIL load_waddr idx %0d got %0d want %0d", i, bank_waddr, pos / 4); end
        checks++; if (bank_wdata !== d) begin errors++; $display("FAIL load_wdata idx %0d got %0d want %0d", i, bank_wdata, d); end
        loaded[i] = d;
        i++;
      end
      @(negedge clk);
      cyc++;
    end
    s_valid  = 1'b0;
    ntt_done = 1'b0;
    checks++; if (i != N) begin errors++; $display("FAIL load_timeout got %0d writes want %0d", i, N); end
    #1;
    checks++; if (ntt_go !== 1'b1) begin errors++; $display("FAIL load_go_pulse got %b want 1", ntt_go); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL run_s_ready got %b want 0", s_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_busy got %b want 1", busy); end
    @(negedge clk);
    checks++; if (ntt_go !== 1'b0) begin errors++; $display("FAIL go_single got %b want 0", ntt_go); end
    for (int j = 0; j < N; j++) begin
      pos = exp_pos(j);
      checks++;
      if (bank_mem[pos % 4][pos / 4] !== loaded[j]) begin
        errors++;
        $display("FAIL bank_content idx %0d got %0d want %0d", j, bank_mem[pos % 4][pos / 4], loaded[j]);
      end
    end
  endtask

  task automatic test_load_back_to_back();
    do_load(1'b0, 1'b0, 1'b0);
`ifdef LOADER_BITREV_EN
    checks++; if (bank_mem[0][64] !== DW'(1)) begin errors++; $display("FAIL bitrev_coef1 got %0d want 1", bank_mem[0][64]); end
`else
    checks++; if (bank_mem[1][0] !== DW'(1)) begin errors++; $display("FAIL natural_coef1 got %0d want 1", bank_mem[1][0]); end
`endif
  endtask

  task automatic test_run_ignores_load_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL run_load_start_s_ready got %b want 0", s_ready); end
    checks++; if (dbg_state !== RUN) begin errors++; $display("FAIL run_load_start_state got %0d want %0d", dbg_state, RUN); end
    @(negedge clk);
  endtask

  task automatic preload_banks();
    for (int k = 0; k < 4; k++) begin
      for (int a = 0; a < N/4; a++) pre_val[k][a] = DW'(4*a + k);
    end
    preload_req = 1'b1;
    @(negedge clk);
    preload_req = 1'b0;
    @(negedge clk);
  endtask

  // Unload after ntt_done; ready pattern is a fixed stall, random, or always high.
  task automatic do_unload(input int stall_at, input int stall_len, input bit rnd_ready, input bit start_on_last);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] head;
    int issued, popped, cyc, first_valid, stalled, last_pop;
    bit rdy;
    for (int j = 0; j < N; j++) exp_q.push_back(bank_mem[j % 4][j / 4]);
    ntt_done = 1'b1;
    @(negedge clk);
    ntt_done = 1'b0;
    issued = 0; popped = 0; cyc = 0; first_valid = -1; stalled = 0; last_pop = -1;
    while (popped < N && cyc < 8*N) begin
      if (rnd_ready) rdy = 1'($urandom_range(0, 1));
      else if (popped >= stall_at && stalled < stall_len) begin rdy = 1'b0; stalled++; end
      else rdy = 1'b1;
      m_ready    = rdy;
      load_start = start_on_last && (popped == N - 1);
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL unload_busy cyc %0d got %b want 1", cyc, busy); end
      if (m_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (m_valid === 1'b1) begin
        head = exp_q[0];
        checks++; if (m_data !== head) begin errors++; $display("FAIL unload_data item %0d got %0d want %0d", popped, m_data, head); end
      end
      if (bank_re === 1'b1) begin
        checks++; if (bank_raddr !== AW'(issued / 4)) begin errors++; $display("FAIL unload_raddr read %0d got %0d want %0d", issued, bank_raddr, issued / 4); end
        issued++;
      end
      if (m_valid === 1'b1 && rdy) begin
        head = exp_q.pop_front();
        popped++;
        last_pop = cyc;
      end
      checks++; if (issued - popped > 2 || issued < popped) begin errors++; $display("FAIL unload_outstanding got %0d want <=2", issued - popped); end
      @(negedge clk);
      cyc++;
    end
    m_ready    = 1'b0;
    load_start = 1'b0;
    checks++; if (popped != N) begin errors++; $display("FAIL unload_timeout got %0d items want %0d", popped, N); end
    checks++; if (issued != N) begin errors++; $display("FAIL unload_reads got %0d want %0d", issued, N); end
    checks++; if (first_valid != 2) begin errors++; $display("FAIL unload_latency got %0d want 2", first_valid); end
    if (!rnd_ready && stall_len == 0) begin
      checks++; if (last_pop != N + 1) begin errors++; $display("FAIL unload_throughput got %0d want %0d", last_pop, N + 1); end
    end
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL unload_idle_busy got %b want 0", busy); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL unload_idle_m_valid got %b want 0", m_valid); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL last_pop_load_start_busy got %b want 0", busy); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL last_pop_load_start_s_ready got %b want 0", s_ready); end
  endtask

  task automatic test_unload_natural();
    preload_banks();
    do_unload(N, 0, 1'b0, 1'b1);
  endtask

  task automatic test_toggle_load_and_stall();
    do_load(1'b1, 1'b1, 1'b1);
    do_unload(100, 10, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_load();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < 37; i++) begin
      s_valid = 1'b1;
      s_data  = DW'($urandom);
      @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = DW'($urandom_range(1, (1 << DW) - 1));
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_s_ready got %b want 0", s_ready); end
    checks++; if (bank_we !== 4'b0) begin errors++; $display("FAIL mid_rst_bank_we got %b want 0", bank_we); end
    checks++; if (bank_wdata !== '0) begin errors++; $display("FAIL mid_rst_wdata got %0d want 0", bank_wdata); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_m_valid got %b want 0", m_valid); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL mid_rst_state got %0d want 0", dbg_state); end
    @(negedge clk);
    rst = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got %b want 0", busy); end
    do_load(1'b0, 1'b1, 1'b0);
    do_unload(N, 0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_idle_ignores_done();
    test_load_back_to_back();
    test_run_ignores_load_start();
    test_unload_natural();
    test_toggle_load_and_stall();
    test_reset_mid_load();
    checks++; if (go_count != 3) begin errors++; $display("FAIL go_total got %0d want 3", go_count); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
